tiny_fpga_cfg_ctrl: RTL and testbench

Configuration sequencer for tiny_fpga. It accepts the bitstream from the host as a byte-wide AXI-stream and serialises it onto the fabric's 1-bit cfg_bitstream stream. It drives the fabric's cfg and run strobes and checks that the bitstream length is correct. It sits between the top-level pin wrapper and tiny_fpga, replacing direct pin control of cfg and run.

---
 rtl/tiny_fpga_cfg_pkg.sv | 29 ++
 rtl/tiny_fpga_cfg_ctrl_serializer.sv | 40 ++++
 rtl/tiny_fpga_cfg_ctrl.sv | 144 ++++++++++++++
 tb/tb_tiny_fpga_cfg_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_fpga_cfg_pkg.sv
// Shared types and CRC-8 helper for the tiny_fpga configuration sequencer.
// The CRC helper is only referenced when TINY_FPGA_CFG_CRC_EN is defined.
package tiny_fpga_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    ERR   = 2'd3
  } cfg_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One byte of CRC-8, MSB first, no reflection, no final xor.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/tiny_fpga_cfg_ctrl_serializer.sv
// Byte-in / bit-out shift register: loads a byte only when empty and emits
// i_nbits of it LSB first, so padding bits of a short final byte never leave.
module cfg_byte_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  input  logic [3:0] i_nbits,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_data
);

  logic [7:0] r_shift;
  logic [3:0] r_cnt;

  // Shift register and remaining-bit count
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_shift <= 8'h00;
      r_cnt   <= 4'd0;
    end else if (i_valid && (r_cnt == 4'd0)) begin
      r_shift <= i_data;
      r_cnt   <= i_nbits;
    end else if ((r_cnt != 4'd0) && i_ready) begin
      r_shift <= {1'b0, r_shift[7:1]};
      r_cnt   <= r_cnt - 4'd1;
    end else begin
      r_shift <= r_shift;
      r_cnt   <= r_cnt;
    end
  end

  assign o_ready = (r_cnt == 4'd0);
  assign o_valid = (r_cnt != 4'd0);
  assign o_data  = r_shift[0];

endmodule

// File: rtl/tiny_fpga_cfg_ctrl.sv
// Configuration sequencer: host byte stream -> fabric 1-bit stream, with cfg/run
// strobes and length checking. Define TINY_FPGA_CFG_CRC_EN for a trailing CRC-8 byte.
module tiny_fpga_cfg_ctrl
  import tiny_fpga_cfg_pkg::*;
#(
  parameter int CFG_BITS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run_en,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic [7:0] s_tdata,
  input  logic       s_tlast,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tdata,
  output logic       m_tlast,
  output logic       cfg,
  output logic       run,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CFG_BYTES = (CFG_BITS + 7) / 8;
  localparam int BYTE_W    = $clog2(CFG_BYTES + 1);
  localparam int BIT_W     = $clog2(CFG_BITS + 1);
  localparam logic [BYTE_W-1:0] BYTE_LIMIT = BYTE_W'(CFG_BYTES);
  localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(CFG_BYTES - 1);
  localparam logic [BIT_W-1:0]  BIT_LIMIT  = BIT_W'(CFG_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(CFG_BITS - 1);
  localparam logic [3:0]        LAST_NBITS = 4'(CFG_BITS - 8 * (CFG_BYTES - 1));

  cfg_state_e        r_state, w_next;
  logic [BYTE_W-1:0] r_byte_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_run;
  logic w_in_load, w_is_data, w_acc, w_bit_hs, w_last_hs, w_len_err;
  logic w_ser_load, w_ser_empty, w_err_cond, w_done_cond;
  logic [3:0] w_nbits;

  assign w_in_load  = (r_state == LOAD);
  assign w_is_data  = (r_byte_cnt < BYTE_LIMIT);
  assign w_acc      = s_tvalid && s_tready;
  assign w_bit_hs   = m_tvalid && m_tready;
  assign w_last_hs  = w_bit_hs && m_tlast;
  assign w_nbits    = (r_byte_cnt == LAST_BYTE) ? LAST_NBITS : 4'd8;
  assign w_ser_load = w_acc && w_is_data && !w_len_err;

`ifdef TINY_FPGA_CFG_CRC_EN
  logic [7:0] r_crc;
  logic       r_bits_done, r_crc_ok;
  logic       w_crc_bad, w_crc_good;

  // tlast belongs on the CRC byte, so any data byte carrying it is an error.
  assign w_len_err   = w_is_data ? s_tlast : !s_tlast;
  assign w_crc_bad   = !w_is_data && (s_tdata != r_crc);
  assign w_crc_good  = w_acc && !w_is_data && !w_len_err && !w_crc_bad;
  assign w_err_cond  = w_acc && (w_len_err || w_crc_bad);
  assign w_done_cond = (r_bits_done || w_last_hs) && (r_crc_ok || w_crc_good);
  assign s_tready    = w_in_load && w_ser_empty && !r_crc_ok;

  // Running CRC and the two completion flags, both cleared outside LOAD
  always_ff @(posedge clk) begin
    if (rst || !w_in_load) begin
      r_crc       <= CRC8_INIT;
      r_bits_done <= 1'b0;
      r_crc_ok    <= 1'b0;
    end else begin
      if (w_ser_load) r_crc <= crc8_byte(r_crc, s_tdata);
      if (w_last_hs) r_bits_done <= 1'b1;
      if (w_crc_good) r_crc_ok <= 1'b1;
    end
  end
`else
  assign w_len_err   = (r_byte_cnt == LAST_BYTE) ? !s_tlast : s_tlast;
  assign w_err_cond  = w_acc && w_len_err;
  assign w_done_cond = w_last_hs;
  assign s_tready    = w_in_load && w_ser_empty && w_is_data;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, READY, ERR: begin
        if (start) w_next = LOAD;
        else       w_next = r_state;
      end
      LOAD: begin
        if (w_err_cond)       w_next = ERR;
        else if (w_done_cond) w_next = READY;
        else                  w_next = LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  // Byte/bit counters: held at zero outside LOAD, saturate at their limits
  always_ff @(posedge clk) begin
    if (rst || !w_in_load) begin
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (w_acc && (r_byte_cnt != BYTE_LIMIT)) r_byte_cnt <= r_byte_cnt + 1'b1;
      if (w_bit_hs && (r_bit_cnt != BIT_LIMIT)) r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Run follows run_en one cycle late and only while READY is held
  always_ff @(posedge clk) begin
    if (rst) r_run <= 1'b0;
    else     r_run <= (r_state == READY) && (w_next == READY) && run_en;
  end

  cfg_byte_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_flush (!w_in_load),
    .i_valid (w_ser_load),
    .o_ready (w_ser_empty),
    .i_data  (s_tdata),
    .i_nbits (w_nbits),
    .o_valid (m_tvalid),
    .i_ready (m_tready),
    .o_data  (m_tdata)
  );

  assign m_tlast = m_tvalid && (r_bit_cnt == LAST_BIT);
  assign cfg     = w_in_load;
  assign busy    = w_in_load;
  assign done    = (r_state == READY);
  assign err     = (r_state == ERR);
  assign run     = r_run;

endmodule

// File: tb/tb_tiny_fpga_cfg_ctrl.sv
// Directed self-checking bench for tiny_fpga_cfg_ctrl with an expected-bit scoreboard.
// With TINY_FPGA_CFG_CRC_EN defined it runs the CRC scenarios at 16 bits instead.
module tb_tiny_fpga_cfg_ctrl;

`ifdef TINY_FPGA_CFG_CRC_EN
  localparam int TB_BITS = 16;
`else
  localparam int TB_BITS = 12;
`endif
  localparam int TB_BYTES = (TB_BITS + 7) / 8;

  typedef struct { logic d; logic l; } bit_t;
  typedef struct { logic [7:0] d; logic l; } byte_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, run_en = 1'b0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic s_tready, m_tvalid, m_tdata, m_tlast, cfg, run, busy, done, err;

  bit_t  exp_q[$];
  byte_t tx_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int byte_idx = 0;
  int exp_bit_idx = 0;

  always #5 clk = ~clk;

  tiny_fpga_cfg_ctrl #(.CFG_BITS(TB_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .run_en(run_en),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .cfg(cfg), .run(run), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed event not expected", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    byte_idx = 0;
    exp_bit_idx = 0;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err, 0);
  endtask

  // Queue a host byte; if the fabric should see it, push its expected bits too.
  task automatic send_byte(input logic [7:0] data, input logic last, input logic ser);
    byte_t b;
    bit_t  e;
    int    nb;
    b.d = data;
    b.l = last;
    tx_q.push_back(b);
    if (ser) begin
      nb = (byte_idx == TB_BYTES - 1) ? (TB_BITS - 8 * (TB_BYTES - 1)) : 8;
      for (int j = 0; j < nb; j++) begin
        e.d = data[j];
        e.l = (exp_bit_idx == TB_BITS - 1);
        exp_q.push_back(e);
        exp_bit_idx++;
      end
    end
    byte_idx++;
  endtask

  // Drive bytes and fabric ready until LOAD ends (or stop_bits bits pass).
  task automatic run_stream(input int mode, input int stop_bits, input int budget);
    int   cyc, nbits;
    logic prev_stall, prev_data;
    bit_t eb;
    cyc = 0; nbits = 0; prev_stall = 1'b0; prev_data = 1'b0;
    forever begin
      if (tx_q.size() > 0) begin
        s_tvalid = 1'b1; s_tdata = tx_q[0].d; s_tlast = tx_q[0].l;
      end else begin
        s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
      end
      case (mode)
        0: m_tready = 1'b1;
        1: m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (!busy) break;
      if (cyc >= budget) begin
        fail_now("stream_budget");
        break;
      end
      chk("cfg_in_load", cfg, 1);
      chk("run_in_load", run, 0);
      if (m_tvalid) chk("sready_while_full", s_tready, 0);
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, prev_data);
      end
      if (s_tvalid && s_tready) void'(tx_q.pop_front());
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          fail_now("extra_bit");
        end else begin
          eb = exp_q.pop_front();
          chk("bit_data", m_tdata, eb.d);
          chk("bit_last", m_tlast, eb.l);
        end
        nbits++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      cyc++;
      step();
      if ((stop_bits > 0) && (nbits >= stop_bits)) break;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic chk_ready_state(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cfg"}, cfg, 0);
    chk({tag, "_bits_left"}, exp_q.size(), 0);
  endtask

  task automatic chk_err_state(input string tag);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg"}, cfg, 0);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_sready"}, s_tready, 0);
    chk({tag, "_mvalid"}, m_tvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_cfg", cfg, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_run", run, 0);
    chk("rst_sready", s_tready, 0);
    chk("rst_mvalid", m_tvalid, 0);
    rst = 1'b0;
    step();
    chk("idle_sready", s_tready, 0);

`ifdef TINY_FPGA_CFG_CRC_EN
    // Good CRC: 0x01, 0x02 -> 0x1B
    run_en = 1'b1;
    pulse_start();
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b1);
    send_byte(8'h1B, 1'b1, 1'b0);
    run_stream(0, 0, 200);
    chk_ready_state("crc_ok");
    chk("crc_ok_run_lag", run, 0);
    step();
    chk("crc_ok_run", run, 1);

    // Bad CRC after all bits already delivered
    pulse_start();
    chk("crc_bad_run_load", run, 0);
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b1);
    send_byte(8'h00, 1'b1, 1'b0);
    run_stream(2, 0, 400);
    chk_err_state("crc_bad");
    step();
    step();
    chk("crc_bad_run_hold", run, 0);
    chk("crc_bad_err_hold", err, 1);
`else
    // Basic load with run_en already high
    run_en = 1'b1;
    pulse_start();
    send_byte(8'hA5, 1'b0, 1'b1);
    send_byte(8'h03, 1'b1, 1'b1);
    run_stream(0, 0, 200);
    chk_ready_state("load");
    chk("load_run_lag", run, 0);
    step();
    chk("load_run_on", run, 1);
    run_en = 1'b0;
    step();
    chk("load_run_off", run, 0);

    // Backpressure 1,0,0,1
    pulse_start();
    chk("reload_done_clr", done, 0);
    send_byte(8'hA5, 1'b0, 1'b1);
    send_byte(8'h03, 1'b1, 1'b1);
    run_stream(1, 0, 400);
    chk_ready_state("bp");

    // Early tlast on the first byte
    pulse_start();
    send_byte(8'hA5, 1'b1, 1'b0);
    run_stream(0, 0, 50);
    chk_err_state("early_tlast");

    // Missing tlast on the last byte: first byte's bits still go out
    pulse_start();
    send_byte(8'hA5, 1'b0, 1'b1);
    send_byte(8'h03, 1'b0, 1'b0);
    run_stream(0, 0, 200);
    chk_err_state("late_tlast");
    chk("late_tlast_bits_left", exp_q.size(), 0);

    // Recovery from ERR with random backpressure and new data
    pulse_start();
    chk("recover_err_clr", err, 0);
    send_byte(8'h3C, 1'b0, 1'b1);
    send_byte(8'hFA, 1'b1, 1'b1);
    run_stream(2, 0, 400);
    chk_ready_state("recover");

    // Reset after five bits, then a clean reload
    pulse_start();
    send_byte(8'hA5, 1'b0, 1'b1);
    send_byte(8'h03, 1'b1, 1'b1);
    run_stream(0, 5, 200);
    rst = 1'b1;
    m_tready = 1'b0;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cfg", cfg, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_mvalid", m_tvalid, 0);
    chk("mid_rst_mdata", m_tdata, 0);
    chk("mid_rst_mlast", m_tlast, 0);
    chk("mid_rst_sready", s_tready, 0);
    rst = 1'b0;
    tx_q.delete();
    exp_q.delete();
    pulse_start();
    send_byte(8'hA5, 1'b0, 1'b1);
    send_byte(8'h03, 1'b1, 1'b1);
    run_stream(0, 0, 200);
    chk_ready_state("after_rst");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
